// File: rtl/uart_rx_if.sv
// Byte-side and serial-line signals of the UART receiver, bundled for the receiver and its consumer.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  data_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples mid-bit, and emits one-cycle data_valid / frame_err strobes.
//   state   | meaning
//   S_IDLE  | line idle, waiting for rx_s low
//   S_START | counting half a bit to confirm the start bit
//   S_DATA  | sampling 8 data bits LSB first, one per bit period
//   S_STOP  | sampling the stop bit
//   S_BREAK | stop bit was low; waiting for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.master bus
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LOAD = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_n;
    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_r, data_n;
    logic          dv_r, dv_n;
    logic          fe_r, fe_n;
    logic          tc;

    // Both flops reset high so the idle line never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_r  <= '0;
            dv_r    <= 1'b0;
            fe_r    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            data_r  <= data_n;
            dv_r    <= dv_n;
            fe_r    <= fe_n;
        end
    end

    assign tc = (cnt == '0);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = data_r;
        dv_n      = 1'b0;
        fe_n      = 1'b0;

        case (state)
            S_IDLE: begin
                bit_idx_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                    cnt_n   = HALF_LOAD;
                end
            end

            S_START: begin
                if (tc) begin
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                        cnt_n     = BIT_LOAD;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            S_DATA: begin
                if (tc) begin
                    shreg_n = {rx_s, shreg[7:1]};
                    cnt_n   = BIT_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            S_STOP: begin
                if (tc) begin
                    if (rx_s) begin
                        data_n  = shreg;
                        dv_n    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            // A held-low line must not be mistaken for a run of new start bits.
            S_BREAK: begin
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.data       = data_r;
    assign bus.data_valid = dv_r;
    assign bus.frame_err  = fe_r;
    assign bus.busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(dv_r && fe_r))
                else $error("data_valid and frame_err high together");
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame, back-to-back, glitch, framing error, mid-frame reset and short-stop cases.
module tb_uart_rx;
    localparam int CPB = 16;

    logic clk;
    logic reset;
    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         dv_cnt = 0;
    int         fe_cnt = 0;
    int         both_cnt = 0;
    int         last_dv_cyc = 0;
    int         fall_cyc = 0;
    logic [7:0] dv_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid) begin
            dv_cnt      = dv_cnt + 1;
            last_dv_cyc = cyc;
            dv_log.push_back(bus.data);
        end
        if (bus.frame_err) fe_cnt = fe_cnt + 1;
        if (bus.data_valid && bus.frame_err) both_cnt = both_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the start bit begins immediately.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
        fall_cyc = cyc;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = stop_v;
        repeat (stop_len) @(negedge clk);
    endtask

    initial begin
        bus.rx = 1'b1;
        reset  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_data", 32'(bus.data), 32'h00);
        check_eq("rst_dv", 32'(bus.data_valid), 32'h0);
        check_eq("rst_fe", 32'(bus.frame_err), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b1;
        idle(20);

        // Single frame A5 with latency check: fall at N, t0 = N+3, strobe edge t0+152.
        fork
            send_frame(8'hA5, 1'b1, CPB);
            begin
                repeat (40) @(negedge clk);
                check_eq("a5_busy_mid", 32'(bus.busy), 32'h1);
            end
        join
        check_eq("a5_dv_cnt", 32'(dv_cnt), 32'd1);
        check_eq("a5_data", 32'(bus.data), 32'hA5);
        check_eq("a5_fe_cnt", 32'(fe_cnt), 32'd0);
        check_eq("a5_latency", 32'(last_dv_cyc - fall_cyc), 32'd155);
        idle(10);

        // Back-to-back with exactly one stop bit between frames.
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        idle(10);
        check_eq("b2b_dv_cnt", 32'(dv_cnt), 32'd3);
        check_eq("b2b_first", 32'(dv_log[1]), 32'h00);
        check_eq("b2b_second", 32'(dv_log[2]), 32'hFF);

        // Glitch: 4 low cycles; t0 = N+3, so busy is up at N+4 and back down by N+12.
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("glitch_busy_hi", 32'(bus.busy), 32'h1);
        bus.rx = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("glitch_busy_lo", 32'(bus.busy), 32'h0);
        idle(40);
        check_eq("glitch_dv_cnt", 32'(dv_cnt), 32'd3);
        check_eq("glitch_fe_cnt", 32'(fe_cnt), 32'd0);

        // Framing error followed by a 3-bit-time break, then a good frame.
        send_frame(8'h3C, 1'b0, CPB);
        bus.rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check_eq("ferr_fe_cnt", 32'(fe_cnt), 32'd1);
        check_eq("ferr_dv_cnt", 32'(dv_cnt), 32'd3);
        check_eq("ferr_data_hold", 32'(bus.data), 32'hFF);
        check_eq("ferr_busy_break", 32'(bus.busy), 32'h1);
        idle(2 * CPB);
        check_eq("ferr_busy_idle", 32'(bus.busy), 32'h0);
        send_frame(8'h5A, 1'b1, CPB);
        idle(10);
        check_eq("after_ferr_data", 32'(bus.data), 32'h5A);
        check_eq("after_ferr_dv", 32'(dv_cnt), 32'd4);

        // Reset in the middle of data bit 3, then a clean frame.
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b0;
        repeat (2 * CPB + CPB / 2) @(negedge clk);
        check_eq("pre_rst_busy", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        #2;
        check_eq("rst_mid_data", 32'(bus.data), 32'h00);
        check_eq("rst_mid_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_mid_dv", 32'(bus.data_valid), 32'h0);
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        idle(3 * CPB);
        check_eq("rst_abort_dv", 32'(dv_cnt), 32'd4);
        send_frame(8'h81, 1'b1, CPB);
        idle(10);
        check_eq("rst_new_data", 32'(bus.data), 32'h81);
        check_eq("rst_new_dv", 32'(dv_cnt), 32'd5);

        // Shortened stop bit: next start edge lands 12 cycles into the stop bit.
        send_frame(8'h96, 1'b1, 12);
        send_frame(8'h69, 1'b1, CPB);
        idle(10);
        check_eq("short_stop_dv", 32'(dv_cnt), 32'd7);
        check_eq("short_stop_first", 32'(dv_log[5]), 32'h96);
        check_eq("short_stop_second", 32'(bus.data), 32'h69);

        // Transmitter-style frame A5 at matched bit period.
        send_frame(8'hA5, 1'b1, CPB);
        idle(20);
        check_eq("loop_data", 32'(bus.data), 32'hA5);
        check_eq("loop_dv", 32'(dv_cnt), 32'd8);
        check_eq("loop_fe_total", 32'(fe_cnt), 32'd1);
        check_eq("never_both", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
